// File: rtl/literal_translation_table.sv
// Programmable literal -> {clause address, clause mask} table for the WalkSAT datapath.
// Ports: clk/reset_n; clear_i soft clear; init_done_o ready flag; cfg_* write port (RUN only);
//        rd_valid_i/rd_index_i/rd_ready_o request side; rd_valid_o/rd_ready_i/rd_index_o/
//        address_o/mask_o response side (latency 1, holds under backpressure).
// Option: define ATT_WR_BYPASS_EN for write-first forwarding on same-index write+read.
module literal_translation_table #(
    parameter int NV                       = 32,
    parameter int LITERAL_ADDRESS_WIDTH    = 11,
    parameter int MAX_CLAUSES_PER_VARIABLE = 20,
    localparam int AT_SIZE                 = 2 * NV,
    localparam int IDX_W                   = $clog2(AT_SIZE)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                clear_i,
    output logic                                init_done_o,
    input  logic                                cfg_we_i,
    input  logic [IDX_W-1:0]                    cfg_index_i,
    input  logic [LITERAL_ADDRESS_WIDTH-1:0]    cfg_address_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] cfg_mask_i,
    input  logic                                rd_valid_i,
    input  logic [IDX_W-1:0]                    rd_index_i,
    output logic                                rd_ready_o,
    output logic                                rd_valid_o,
    input  logic                                rd_ready_i,
    output logic [IDX_W-1:0]                    rd_index_o,
    output logic [LITERAL_ADDRESS_WIDTH-1:0]    address_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_o
);

    localparam int AW = LITERAL_ADDRESS_WIDTH;
    localparam int MW = MAX_CLAUSES_PER_VARIABLE;
    localparam int W  = AW + MW;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(AT_SIZE - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [W-1:0]     mem [AT_SIZE];

    logic             sweep_en;
    logic             wr_en;
    logic             rd_accept;
    logic [W-1:0]     wr_data;
    logic [W-1:0]     rd_data;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT: begin
                if (!clear_i && cnt == LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (clear_i) begin
                    state_nxt = S_INIT;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Outputs / strobes decoded from state
    always_comb begin
        init_done_o = (state == S_RUN);
        sweep_en    = (state == S_INIT);
        // A clear in the same cycle drops the write.
        wr_en       = (state == S_RUN) & cfg_we_i & ~clear_i;
    end

    // Sweep counter; parked at 0 in RUN so a clear always restarts from entry 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (sweep_en && !clear_i) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    assign wr_data = {cfg_address_i, cfg_mask_i};

    // Storage has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (sweep_en) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            mem[cfg_index_i] <= wr_data;
        end
    end

    assign rd_ready_o = init_done_o & (~rd_valid_o | rd_ready_i);
    assign rd_accept  = rd_valid_i & rd_ready_o;

`ifdef ATT_WR_BYPASS_EN
    assign rd_data = (wr_en && cfg_index_i == rd_index_i) ? wr_data : mem[rd_index_i];
`else
    assign rd_data = mem[rd_index_i];
`endif

    // Response stage: loads on accept, holds under backpressure, data kept when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_o <= 1'b0;
            rd_index_o <= '0;
            address_o  <= '0;
            mask_o     <= '0;
        end else if (clear_i || !init_done_o) begin
            rd_valid_o <= 1'b0;
        end else if (rd_accept) begin
            rd_valid_o <= 1'b1;
            rd_index_o <= rd_index_i;
            address_o  <= rd_data[W-1:MW];
            mask_o     <= rd_data[MW-1:0];
        end else if (rd_ready_i) begin
            rd_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_literal_translation_table.sv
// Scoreboard bench for literal_translation_table.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_literal_translation_table;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear_i;
    logic        init_done_o;
    logic        cfg_we_i;
    logic [5:0]  cfg_index_i;
    logic [10:0] cfg_address_i;
    logic [19:0] cfg_mask_i;
    logic        rd_valid_i;
    logic [5:0]  rd_index_i;
    logic        rd_ready_o;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic [5:0]  rd_index_o;
    logic [10:0] address_o;
    logic [19:0] mask_o;

    literal_translation_table dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear_i       (clear_i),
        .init_done_o   (init_done_o),
        .cfg_we_i      (cfg_we_i),
        .cfg_index_i   (cfg_index_i),
        .cfg_address_i (cfg_address_i),
        .cfg_mask_i    (cfg_mask_i),
        .rd_valid_i    (rd_valid_i),
        .rd_index_i    (rd_index_i),
        .rd_ready_o    (rd_ready_o),
        .rd_valid_o    (rd_valid_o),
        .rd_ready_i    (rd_ready_i),
        .rd_index_o    (rd_index_o),
        .address_o     (address_o),
        .mask_o        (mask_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  idx;
        logic [10:0] a;
        logic [19:0] m;
    } rsp_t;

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } dchk_t;

    rsp_t  sbq[$];
    dchk_t dq[$];
    int    checks = 0;
    int    errors = 0;
    rsp_t  e;
    dchk_t d;

    // Monitor: sole owner of the check/error counters.
    always @(negedge clk) begin
        while (dq.size() > 0) begin
            d = dq.pop_front();
            checks++;
            if (d.act !== d.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", d.nm, d.act, d.exp);
            end
        end
        if (reset_n === 1'b1 && rd_valid_o && rd_ready_i) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got idx %0d expected none", rd_index_o);
            end else begin
                e = sbq.pop_front();
                if ({rd_index_o, address_o, mask_o} !== {e.idx, e.a, e.m}) begin
                    errors++;
                    $display("FAIL rsp: got idx %0d addr %h mask %h expected idx %0d addr %h mask %h",
                             rd_index_o, address_o, mask_o, e.idx, e.a, e.m);
                end
            end
        end
    end

    task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        dq.push_back('{nm, act, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [5:0] idx, input logic [10:0] a, input logic [19:0] m);
        cfg_we_i      = 1'b1;
        cfg_index_i   = idx;
        cfg_address_i = a;
        cfg_mask_i    = m;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic rd(input logic [5:0] idx, input logic [10:0] a, input logic [19:0] m);
        bit ok = 0;
        rd_valid_i = 1'b1;
        rd_index_i = idx;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (rd_ready_o) begin
                sbq.push_back('{idx, a, m});
                ok = 1;
            end
            tick();
        end
        rd_valid_i = 1'b0;
        if (!ok) dchk("rd_accept_timeout", 0, 1);
    endtask

    // Counts negedges with init_done_o low; expects exactly 64.
    task automatic count_init(input string nm);
        int n = 0;
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (init_done_o) begin
                done = 1;
            end else begin
                n++;
                if (rd_ready_o !== 1'b0) dchk({nm, "_ready_in_init"}, 32'(rd_ready_o), 0);
                if (rd_valid_o !== 1'b0) dchk({nm, "_valid_in_init"}, 32'(rd_valid_o), 0);
            end
        end
        dchk({nm, "_init_cycles"}, n, 64);
        tick();
    endtask

    initial begin
        reset_n       = 1'b0;
        clear_i       = 1'b0;
        cfg_we_i      = 1'b0;
        cfg_index_i   = '0;
        cfg_address_i = '0;
        cfg_mask_i    = '0;
        rd_valid_i    = 1'b0;
        rd_index_i    = '0;
        rd_ready_i    = 1'b1;

        repeat (3) tick();
        dchk("rst_init_done", 32'(init_done_o), 0);
        dchk("rst_valid", 32'(rd_valid_o), 0);
        dchk("rst_outputs", {rd_index_o, address_o, mask_o}, 0);
        reset_n = 1'b1;
        count_init("reset");

        // Swept entry reads as zero
        rd(5, 11'h000, 20'h00000);

        // Write then read
        cfg_write(7, 11'h2A5, 20'hF00F1);
        rd(7, 11'h2A5, 20'hF00F1);

        // Back-to-back with backpressure on response 2
        cfg_write(1, 11'h101, 20'h11111);
        cfg_write(2, 11'h202, 20'h22222);
        cfg_write(3, 11'h303, 20'h33333);
        repeat (2) tick();
        rd(1, 11'h101, 20'h11111);
        rd(2, 11'h202, 20'h22222);
        rd_ready_i = 1'b0;
        rd_valid_i = 1'b1;
        rd_index_i = 6'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dchk("stall_ready", 32'(rd_ready_o), 0);
            dchk("stall_valid", 32'(rd_valid_o), 1);
            dchk("stall_hold", {rd_index_o, address_o, mask_o}, {6'd2, 11'h202, 20'h22222});
            tick();
        end
        rd_ready_i = 1'b1;
        rd(3, 11'h303, 20'h33333);
        repeat (2) tick();

        // Same-cycle write + read of idx 9
        cfg_we_i      = 1'b1;
        cfg_index_i   = 6'd9;
        cfg_address_i = 11'h011;
        cfg_mask_i    = 20'h00000;
        rd_valid_i    = 1'b1;
        rd_index_i    = 6'd9;
        @(negedge clk);
        if (rd_ready_o) begin
`ifdef ATT_WR_BYPASS_EN
            sbq.push_back('{6'd9, 11'h011, 20'h00000});
`else
            sbq.push_back('{6'd9, 11'h000, 20'h00000});
`endif
        end else begin
            dchk("same_cycle_accept", 0, 1);
        end
        tick();
        cfg_we_i   = 1'b0;
        rd_valid_i = 1'b0;
        rd(9, 11'h011, 20'h00000);
        repeat (2) tick();

        // Clear with a response pending
        rd_ready_i = 1'b0;
        rd_valid_i = 1'b1;
        rd_index_i = 6'd7;
        @(negedge clk);
        dchk("pend_accept", 32'(rd_ready_o), 1);
        tick();
        rd_valid_i = 1'b0;
        @(negedge clk);
        dchk("pend_valid", 32'(rd_valid_o), 1);
        tick();
        clear_i       = 1'b1;
        cfg_we_i      = 1'b1;
        cfg_index_i   = 6'd7;
        cfg_address_i = 11'h7FF;
        cfg_mask_i    = 20'hFFFFF;
        tick();
        clear_i    = 1'b0;
        cfg_we_i   = 1'b0;
        rd_ready_i = 1'b1;
        count_init("clear");
        rd(7, 11'h000, 20'h00000);
        cfg_write(4, 11'h3C3, 20'hABCDE);
        rd(4, 11'h3C3, 20'hABCDE);
        repeat (2) tick();

        // Reset in the middle of a resweep
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        repeat (10) tick();
        dchk("mid_sweep_busy", 32'(init_done_o), 0);
        reset_n = 1'b0;
        #1;
        dchk("mid_rst_valid", 32'(rd_valid_o), 0);
        dchk("mid_rst_outputs", {rd_index_o, address_o, mask_o}, 0);
        dchk("mid_rst_init_done", 32'(init_done_o), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        count_init("reset2");
        rd(4, 11'h000, 20'h00000);

        repeat (3) tick();
        dchk("sb_empty", sbq.size(), 0);
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
